// File: rtl/rob_retire_pkg.sv
// Shared types and sizes for the reorder buffer back end.
// Row layout and the free-pool release packet live here so rename can reuse them.
package rob_retire_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PREG_W    = 6;

  typedef struct packed {
    logic              v;
    logic              done;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [31:0]       pc;
  } rob_row_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
  } retire_pkt_t;

endpackage

// File: rtl/rob_retire.sv
// 16-entry reorder buffer: dual allocate, dual writeback, in-order dual retire.
// Retiring rows hand their previous physical destination back to the rename free pool.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_1,
  input  logic [PREG_W-1:0] alloc_pd_1,
  input  logic [PREG_W-1:0] alloc_old_pd_1,
  input  logic [31:0]       alloc_pc_1,
  input  logic              alloc_req_2,
  input  logic [PREG_W-1:0] alloc_pd_2,
  input  logic [PREG_W-1:0] alloc_old_pd_2,
  input  logic [31:0]       alloc_pc_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  input  logic              wb_valid_1,
  input  logic [IDX_W-1:0]  wb_rob_idx_1,
  input  logic              wb_valid_2,
  input  logic [IDX_W-1:0]  wb_rob_idx_2,
  output logic              free_valid_1,
  output logic [PREG_W-1:0] free_preg_1,
  output logic              free_valid_2,
  output logic [PREG_W-1:0] free_preg_2,
  output logic [1:0]        retire_count,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  localparam int unsigned CNT_W = IDX_W + 1;

  rob_row_t         rob_q [ROB_DEPTH];
  rob_row_t         rob_d [ROB_DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_nx, slot2_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alloc_ready_q, alloc_ready_d;
  retire_pkt_t      pkt_1_q, pkt_1_d, pkt_2_q, pkt_2_d;
  logic [1:0]       retire_count_q, retire_count_d;
  logic [1:0]       alloc_n;
  logic             a1, a2, r1, r2;

  // Gated requests: anything arriving while not ready is dropped.
  assign a1        = alloc_req_1 & alloc_ready_q;
  assign a2        = alloc_req_2 & alloc_ready_q;
  assign slot2_idx = tail_q + IDX_W'(alloc_req_1);
  assign head_nx   = head_q + IDX_W'(1);

  assign r1 = rob_q[head_q].v & rob_q[head_q].done;
  assign r2 = r1 & rob_q[head_nx].v & rob_q[head_nx].done;

  assign alloc_n        = {1'b0, a1} + {1'b0, a2};
  assign retire_count_d = {1'b0, r1} + {1'b0, r2};
  assign head_d         = head_q + IDX_W'(retire_count_d);
  assign tail_d         = tail_q + IDX_W'(alloc_n);
  assign count_d        = count_q + CNT_W'(alloc_n) - CNT_W'(retire_count_d);
  assign alloc_ready_d  = (count_d <= CNT_W'(ROB_DEPTH - 2));

  // Rows being allocated never overlap rows being retired: alloc_ready keeps two free.
  always_comb begin
    rob_d = rob_q;
    if (wb_valid_1 && rob_q[wb_rob_idx_1].v) rob_d[wb_rob_idx_1].done = 1'b1;
    if (wb_valid_2 && rob_q[wb_rob_idx_2].v) rob_d[wb_rob_idx_2].done = 1'b1;
    if (r1) rob_d[head_q]  = '0;
    if (r2) rob_d[head_nx] = '0;
    if (a1) begin
      rob_d[tail_q] = '{v: 1'b1, done: 1'b0, pd: alloc_pd_1, old_pd: alloc_old_pd_1,
                        pc: alloc_pc_1};
    end
    if (a2) begin
      rob_d[slot2_idx] = '{v: 1'b1, done: 1'b0, pd: alloc_pd_2, old_pd: alloc_old_pd_2,
                           pc: alloc_pc_2};
    end
  end

  // p0 is the hard zero register and is never returned to the pool.
  always_comb begin
    pkt_1_d.valid = r1 & (rob_q[head_q].old_pd != '0);
    pkt_1_d.preg  = r1 ? rob_q[head_q].old_pd : '0;
    pkt_2_d.valid = r2 & (rob_q[head_nx].old_pd != '0);
    pkt_2_d.preg  = r2 ? rob_q[head_nx].old_pd : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      alloc_ready_q  <= 1'b1;
      pkt_1_q        <= '0;
      pkt_2_q        <= '0;
      retire_count_q <= '0;
    end else begin
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      alloc_ready_q  <= alloc_ready_d;
      pkt_1_q        <= pkt_1_d;
      pkt_2_q        <= pkt_2_d;
      retire_count_q <= retire_count_d;
    end
  end

  // pd and pc travel with the row for debug visibility; retirement does not consume them.
  logic unused_row;
  assign unused_row = ^{rob_q[head_q].pd, rob_q[head_q].pc};

  assign alloc_ready  = alloc_ready_q;
  assign alloc_idx_1  = tail_q;
  assign alloc_idx_2  = slot2_idx;
  assign free_valid_1 = pkt_1_q.valid;
  assign free_preg_1  = pkt_1_q.preg;
  assign free_valid_2 = pkt_2_q.valid;
  assign free_preg_2  = pkt_2_q.preg;
  assign retire_count = retire_count_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: program-order queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              alloc_req_1, alloc_req_2;
  logic [PREG_W-1:0] alloc_pd_1, alloc_old_pd_1, alloc_pd_2, alloc_old_pd_2;
  logic [31:0]       alloc_pc_1, alloc_pc_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;
  logic              wb_valid_1, wb_valid_2;
  logic [IDX_W-1:0]  wb_rob_idx_1, wb_rob_idx_2;
  logic              free_valid_1, free_valid_2;
  logic [PREG_W-1:0] free_preg_1, free_preg_2;
  logic [1:0]        retire_count;
  logic [IDX_W:0]    count;
  logic              empty;

  rob_retire dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req_1    (alloc_req_1),
    .alloc_pd_1     (alloc_pd_1),
    .alloc_old_pd_1 (alloc_old_pd_1),
    .alloc_pc_1     (alloc_pc_1),
    .alloc_req_2    (alloc_req_2),
    .alloc_pd_2     (alloc_pd_2),
    .alloc_old_pd_2 (alloc_old_pd_2),
    .alloc_pc_2     (alloc_pc_2),
    .alloc_ready    (alloc_ready),
    .alloc_idx_1    (alloc_idx_1),
    .alloc_idx_2    (alloc_idx_2),
    .wb_valid_1     (wb_valid_1),
    .wb_rob_idx_1   (wb_rob_idx_1),
    .wb_valid_2     (wb_valid_2),
    .wb_rob_idx_2   (wb_rob_idx_2),
    .free_valid_1   (free_valid_1),
    .free_preg_1    (free_preg_1),
    .free_valid_2   (free_valid_2),
    .free_preg_2    (free_preg_2),
    .retire_count   (retire_count),
    .count          (count),
    .empty          (empty)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: in-flight instructions in program order.
  typedef struct {
    int idx;
    int old_pd;
    bit done;
  } ent_t;

  ent_t mq[$];
  int   m_next;
  bit   m_ready;
  int   m_rc;
  bit   m_fv1, m_fv2;
  int   m_fp1, m_fp2;
  bit   chk_en = 1'b0;
  int   pc_ctr = 32'h1000;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_next  = 0;
      m_ready = 1'b1;
      m_rc    = 0;
      m_fv1   = 1'b0;
      m_fv2   = 1'b0;
      m_fp1   = 0;
      m_fp2   = 0;
    end else begin
      m_rc = 0;
      if (mq.size() >= 1 && mq[0].done) m_rc = (mq.size() >= 2 && mq[1].done) ? 2 : 1;
      m_fv1 = (m_rc >= 1) && (mq[0].old_pd != 0);
      m_fp1 = (m_rc >= 1) ? mq[0].old_pd : 0;
      m_fv2 = (m_rc == 2) && (mq[1].old_pd != 0);
      m_fp2 = (m_rc == 2) ? mq[1].old_pd : 0;
      repeat (m_rc) void'(mq.pop_front());
      foreach (mq[i]) begin
        if ((wb_valid_1 && mq[i].idx == int'(wb_rob_idx_1)) ||
            (wb_valid_2 && mq[i].idx == int'(wb_rob_idx_2))) mq[i].done = 1'b1;
      end
      if (m_ready) begin
        if (alloc_req_1) begin
          mq.push_back('{m_next, int'(alloc_old_pd_1), 1'b0});
          m_next = (m_next + 1) % ROB_DEPTH;
        end
        if (alloc_req_2) begin
          mq.push_back('{m_next, int'(alloc_old_pd_2), 1'b0});
          m_next = (m_next + 1) % ROB_DEPTH;
        end
      end
      m_ready = (mq.size() <= ROB_DEPTH - 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("alloc_ready", int'(alloc_ready), int'(m_ready));
      chk("retire_count", int'(retire_count), m_rc);
      chk("free_valid_1", int'(free_valid_1), int'(m_fv1));
      chk("free_valid_2", int'(free_valid_2), int'(m_fv2));
      if (m_rc >= 1) chk("free_preg_1", int'(free_preg_1), m_fp1);
      if (m_rc == 2) chk("free_preg_2", int'(free_preg_2), m_fp2);
      chk("alloc_idx_1", int'(alloc_idx_1), m_next);
      chk("alloc_idx_2", int'(alloc_idx_2), (m_next + int'(alloc_req_1)) % ROB_DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_req_1 = 1'b0;
    alloc_req_2 = 1'b0;
    wb_valid_1  = 1'b0;
    wb_valid_2  = 1'b0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic set_alloc(input bit r1, input int pd1, input int old1,
                           input bit r2, input int pd2, input int old2);
    clr();
    alloc_req_1    = r1;
    alloc_pd_1     = pd1[PREG_W-1:0];
    alloc_old_pd_1 = old1[PREG_W-1:0];
    alloc_pc_1     = pc_ctr;
    alloc_req_2    = r2;
    alloc_pd_2     = pd2[PREG_W-1:0];
    alloc_old_pd_2 = old2[PREG_W-1:0];
    alloc_pc_2     = pc_ctr + 4;
    pc_ctr        += 8;
  endtask

  task automatic alloc2(input bit r1, input int pd1, input int old1,
                        input bit r2, input int pd2, input int old2);
    set_alloc(r1, pd1, old1, r2, pd2, old2);
    tick();
    clr();
  endtask

  task automatic wb(input bit v1, input int i1, input bit v2, input int i2);
    clr();
    wb_valid_1   = v1;
    wb_rob_idx_1 = i1[IDX_W-1:0];
    wb_valid_2   = v2;
    wb_rob_idx_2 = i2[IDX_W-1:0];
    tick();
    clr();
  endtask

  task automatic pulse_rst();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_alloc(0, 0, 0, 0, 0, 0);
    wb_rob_idx_1 = '0;
    wb_rob_idx_2 = '0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ready", int'(alloc_ready), 1);
    chk("rst_retire_count", int'(retire_count), 0);
    chk("rst_free_valid_1", int'(free_valid_1), 0);
    rst = 1'b0;

    // Basic flow: dual alloc, dual writeback, dual retire.
    alloc2(1, 32, 5, 1, 33, 6);
    wb(1, 0, 1, 1);
    idle(1);
    chk("basic_free_preg_1", int'(free_preg_1), 5);
    chk("basic_free_preg_2", int'(free_preg_2), 6);
    chk("basic_free_valid_1", int'(free_valid_1), 1);
    chk("basic_free_valid_2", int'(free_valid_2), 1);
    chk("basic_retire_count", int'(retire_count), 2);
    chk("basic_empty", int'(empty), 1);

    // Out-of-order completion: younger completes first, nothing retires.
    alloc2(1, 34, 7, 1, 35, 8);
    wb(0, 0, 1, 3);
    idle(2);
    chk("ooo_hold_retire_count", int'(retire_count), 0);
    chk("ooo_hold_count", int'(count), 2);
    wb(1, 2, 0, 0);
    idle(1);
    chk("ooo_retire_count", int'(retire_count), 2);
    chk("ooo_free_preg_1", int'(free_preg_1), 7);
    chk("ooo_free_preg_2", int'(free_preg_2), 8);

    // Full ROB, dropped request, then drain two.
    pulse_rst();
    for (int i = 0; i < 8; i++) alloc2(1, 32 + 2 * i, 10 + 2 * i, 1, 33 + 2 * i, 11 + 2 * i);
    chk("full_count", int'(count), 16);
    chk("full_ready", int'(alloc_ready), 0);
    alloc2(1, 60, 30, 1, 61, 31);
    chk("full_drop_count", int'(count), 16);
    chk("full_drop_tail", int'(alloc_idx_1), 0);
    wb(1, 0, 1, 1);
    idle(1);
    chk("full_drain_ready", int'(alloc_ready), 1);
    chk("full_drain_retire_count", int'(retire_count), 2);
    chk("full_drain_free_preg_1", int'(free_preg_1), 10);
    chk("full_drain_free_preg_2", int'(free_preg_2), 11);
    chk("full_drain_count", int'(count), 14);

    // Wrap-around: move head/tail to 14, then allocate across the wrap.
    pulse_rst();
    for (int i = 0; i < 7; i++) alloc2(1, 40 + 2 * i, 1 + 2 * i, 1, 41 + 2 * i, 2 + 2 * i);
    for (int i = 0; i < 7; i++) wb(1, 2 * i, 1, 2 * i + 1);
    idle(2);
    chk("wrap_drained_count", int'(count), 0);
    chk("wrap_tail", int'(alloc_idx_1), 14);
    set_alloc(1, 54, 20, 1, 55, 21);
    #1;
    chk("wrap_alloc_idx_1a", int'(alloc_idx_1), 14);
    chk("wrap_alloc_idx_2a", int'(alloc_idx_2), 15);
    tick();
    set_alloc(1, 56, 22, 1, 57, 23);
    #1;
    chk("wrap_alloc_idx_1b", int'(alloc_idx_1), 0);
    chk("wrap_alloc_idx_2b", int'(alloc_idx_2), 1);
    tick();
    clr();
    wb(1, 0, 1, 1);
    wb(1, 14, 1, 15);
    idle(1);
    chk("wrap_first_free_preg_1", int'(free_preg_1), 20);
    chk("wrap_first_free_preg_2", int'(free_preg_2), 21);
    idle(1);
    chk("wrap_second_free_preg_1", int'(free_preg_1), 22);
    chk("wrap_second_free_preg_2", int'(free_preg_2), 23);
    chk("wrap_second_retire_count", int'(retire_count), 2);

    // Zero register is never freed; duplicate writeback index on both ports.
    alloc2(1, 50, 0, 0, 0, 0);
    wb(1, 2, 1, 2);
    idle(1);
    chk("p0_retire_count", int'(retire_count), 1);
    chk("p0_free_valid_1", int'(free_valid_1), 0);
    chk("p0_free_valid_2", int'(free_valid_2), 0);

    // Lone slot 2 lands at tail.
    set_alloc(0, 0, 0, 1, 51, 9);
    #1;
    chk("lone2_alloc_idx_2", int'(alloc_idx_2), 3);
    chk("lone2_alloc_idx_1", int'(alloc_idx_1), 3);
    tick();
    clr();
    wb(1, 3, 0, 0);
    idle(1);
    chk("lone2_retire_count", int'(retire_count), 1);
    chk("lone2_free_valid_1", int'(free_valid_1), 1);
    chk("lone2_free_preg_1", int'(free_preg_1), 9);

    // Reset mid-operation with a retirable head pair pending.
    alloc2(1, 20, 11, 1, 21, 12);
    alloc2(1, 22, 13, 1, 23, 14);
    alloc2(1, 24, 15, 0, 0, 0);
    chk("midrst_pre_count", int'(count), 5);
    wb(1, 4, 1, 5);
    pulse_rst();
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_free_valid_1", int'(free_valid_1), 0);
    chk("midrst_free_valid_2", int'(free_valid_2), 0);
    chk("midrst_retire_count", int'(retire_count), 0);
    wb(1, 0, 1, 4);
    idle(3);
    chk("stale_free_valid_1", int'(free_valid_1), 0);
    chk("stale_count", int'(count), 0);
    alloc2(1, 25, 16, 0, 0, 0);
    idle(2);
    chk("stale_no_retire", int'(retire_count), 0);
    chk("stale_count_1", int'(count), 1);
    wb(1, 0, 0, 0);
    idle(1);
    chk("post_rst_retire_count", int'(retire_count), 1);
    chk("post_rst_free_preg_1", int'(free_preg_1), 16);
    chk("post_rst_empty", int'(empty), 1);

    idle(1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
